// File: rtl/s2p_pkg.sv
// Shared types and limits for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_deser.sv
// Framed serial-to-parallel deserializer with a one-word valid/ready holding
// register, per-frame bit order, and sticky overrun / framing-error flags.
module serial_to_parallel_deser
  import s2p_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             CLOCK_50_B5B,
  input  logic             RESET,
  input  logic             ser_din,
  input  logic             ser_en,
  input  logic             ser_frame,
  input  logic             msb_first,
  output logic [WIDTH-1:0] par_dout,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_to_parallel_deser: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             order_q, order_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic done, load, ovr_set, ferr_set;

  // MSB-first enters at the LSB and walks up; LSB-first enters at the MSB and walks down.
  function automatic logic [WIDTH-1:0] ins_bit(input logic [WIDTH-1:0] sh,
                                               input logic b, input logic msb);
    if (msb) return {sh[WIDTH-2:0], b};
    else     return {b, sh[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    order_d  = order_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    ferr_set = 1'b0;
    if (ser_en) begin
      if (ser_frame) begin
        // A frame bit always restarts; inside a word it aborts the partial one.
        ferr_set = (state_q == S_SHIFT);
        shreg_d  = ins_bit('0, ser_din, msb_first);
        order_d  = msb_first;
        cnt_d    = CNT_W'(1);
        state_d  = S_SHIFT;
      end else if (state_q == S_SHIFT) begin
        shreg_d = ins_bit(shreg_q, ser_din, order_q);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    load    = done && (!vld_q || par_ready);
    ovr_set = done && !load;
    hold_d  = hold_q;
    vld_d   = vld_q;
    if (vld_q && par_ready) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      hold_d = shreg_d;
    end
    ovr_d  = clr_flags ? 1'b0 : ovr_q;
    ferr_d = clr_flags ? 1'b0 : ferr_q;
    if (ovr_set)  ovr_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50_B5B or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      hold_q  <= '0;
      order_q <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign par_dout  = hold_q;
  assign par_valid = vld_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == S_SHIFT);
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// Bench for serial_to_parallel_deser at WIDTH=8 and WIDTH=12 against a queue-based model.
module tb_serial_to_parallel_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_r = 1'b0, din_r = 1'b0, frm_r = 1'b0, msb_r = 1'b0, rdy_r = 1'b0, clr_r = 1'b0;
  int          sel = 0;
  int          W = 8;

  logic [7:0]  dout8;
  logic [11:0] dout12;
  logic [3:0]  cnt8, cnt12;
  logic        vld8, vld12, busy8, busy12, ovr8, ovr12, ferr8, ferr12;
  logic        en8, en12;

  assign en8  = en_r & (sel == 0);
  assign en12 = en_r & (sel == 1);

  always #5 clk = ~clk;

  serial_to_parallel_deser #(.WIDTH(8)) u_d8 (
    .CLOCK_50_B5B(clk), .RESET(rst), .ser_din(din_r), .ser_en(en8), .ser_frame(frm_r),
    .msb_first(msb_r), .par_dout(dout8), .par_valid(vld8), .par_ready(rdy_r),
    .bit_cnt(cnt8), .busy(busy8), .overrun(ovr8), .frame_err(ferr8), .clr_flags(clr_r));

  serial_to_parallel_deser #(.WIDTH(12)) u_d12 (
    .CLOCK_50_B5B(clk), .RESET(rst), .ser_din(din_r), .ser_en(en12), .ser_frame(frm_r),
    .msb_first(msb_r), .par_dout(dout12), .par_valid(vld12), .par_ready(rdy_r),
    .bit_cnt(cnt12), .busy(busy12), .overrun(ovr12), .frame_err(ferr12), .clr_flags(clr_r));

  logic [31:0] o_dout, o_cnt;
  logic        o_vld, o_busy, o_ovr, o_ferr;
  always_comb begin
    o_dout = '0; o_cnt = '0; o_vld = 1'b0; o_busy = 1'b0; o_ovr = 1'b0; o_ferr = 1'b0;
    if (sel == 0) begin
      o_dout = {24'd0, dout8}; o_cnt = {28'd0, cnt8}; o_vld = vld8;
      o_busy = busy8; o_ovr = ovr8; o_ferr = ferr8;
    end else begin
      o_dout = {20'd0, dout12}; o_cnt = {28'd0, cnt12}; o_vld = vld12;
      o_busy = busy12; o_ovr = ovr12; o_ferr = ferr12;
    end
  end

  // Reference model: the word in progress is just the list of bits received so far.
  bit          mq[$];
  bit          m_in, m_ord, m_vld, m_ovr, m_ferr;
  logic [31:0] m_dout;
  int          total = 0, bad = 0, vev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_in = 0; m_ord = 0; m_vld = 0; m_ovr = 0; m_ferr = 0; m_dout = '0;
  endtask

  task automatic model_step();
    bit          load = 0, oset = 0, fset = 0;
    logic [31:0] w = '0;
    if (en_r) begin
      if (frm_r) begin
        if (m_in) fset = 1;
        mq.delete(); mq.push_back(din_r); m_ord = msb_r; m_in = 1;
      end else if (m_in) begin
        mq.push_back(din_r);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++)
            if (mq[i]) w = w | (32'd1 << (m_ord ? (W - 1 - i) : i));
          if (!m_vld || rdy_r) load = 1; else oset = 1;
          mq.delete(); m_in = 0;
        end
      end
    end
    if (m_vld && rdy_r) m_vld = 0;
    if (load) begin m_vld = 1; m_dout = w; end
    if (clr_r) begin m_ovr = 0; m_ferr = 0; end
    if (oset) m_ovr = 1;
    if (fset) m_ferr = 1;
  endtask

  task automatic check_all();
    chk("dout", o_dout, m_dout);
    chk("valid", {31'd0, o_vld}, {31'd0, m_vld});
    chk("bit_cnt", o_cnt, mq.size());
    chk("busy", {31'd0, o_busy}, {31'd0, m_in});
    chk("overrun", {31'd0, o_ovr}, {31'd0, m_ovr});
    chk("frame_err", {31'd0, o_ferr}, {31'd0, m_ferr});
    if (o_vld === 1'b1) vev++;
  endtask

  task automatic step(input bit en, input bit din, input bit frm, input bit msb,
                      input bit rdy, input bit clr);
    @(negedge clk);
    en_r = en; din_r = din; frm_r = frm; msb_r = msb; rdy_r = rdy; clr_r = clr;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    en_r = 0; din_r = 0; frm_r = 0; msb_r = 0; rdy_r = 0; clr_r = 0;
    rst = 1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send_word(input logic [31:0] v, input bit msb, input bit rdy, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, msb ? v[W-1-i] : v[i], i == 0, msb, rdy, 1'b0);
      repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b1011_0010;
    sel = 0; W = 8;
    do_reset();

    // MSB-first reference pattern
    for (int i = 0; i < 8; i++) step(1, pat[7-i], i == 0, 1, 1, 0);
    chk("b2_dout", o_dout, 32'hB2);
    chk("b2_valid", {31'd0, o_vld}, 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // LSB-first, msb_first toggled mid-word must be ignored
    for (int i = 0; i < 8; i++) step(1, pat[7-i], i == 0, (i == 0) ? 1'b0 : 1'(i % 2), 1, 0);
    chk("4d_dout", o_dout, 32'h4D);
    step(0, 0, 0, 0, 1, 0);

    // Overrun with consumer stalled
    send_word(32'hA5, 1, 0, 0);
    send_word(32'h3C, 1, 0, 0);
    chk("ovr_hold", o_dout, 32'hA5);
    chk("ovr_flag", {31'd0, o_ovr}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", {31'd0, o_ovr}, 32'd0);

    // Held word consumed on the very cycle the next completes: no overrun
    for (int i = 0; i < 8; i++) step(1, 1'(i % 3 == 0), i == 0, 1, i == 7, 0);
    chk("coinc_dout", o_dout, 32'h92);
    chk("coinc_ovr", {31'd0, o_ovr}, 32'd0);

    // Clear coinciding with an overrun event: set wins
    for (int i = 0; i < 8; i++) step(1, 1'b1, i == 0, 1, 0, i == 7);
    chk("clr_vs_set", {31'd0, o_ovr}, 32'd1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);

    // Early frame start aborts the partial word
    vev = 0;
    for (int i = 0; i < 5; i++) step(1, 1'b1, i == 0, 1, 1, 0);
    send_word(32'hF0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("ferr_flag", {31'd0, o_ferr}, 32'd1);
    chk("ferr_dout", o_dout, 32'hF0);
    chk("ferr_events", vev, 32'd1);

    // Reset in the middle of a word
    for (int i = 0; i < 4; i++) step(1, 1'b1, i == 0, 1, 1, 0);
    do_reset();
    send_word(32'h81, 1, 1, 0);
    chk("rst_dout", o_dout, 32'h81);
    chk("rst_flags", {30'd0, o_ovr, o_ferr}, 32'd0);

    rand_run(600);

    sel = 1; W = 12;
    do_reset();
    send_word(32'hABC, 1, 1, 2);
    chk("abc_dout", o_dout, 32'hABC);
    send_word(32'h5A3, 0, 1, 0);
    chk("5a3_dout", o_dout, 32'h5A3);
    rand_run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
